// File: rtl/pc_seq_pkg.sv
// Shared state encoding and constants for the next-PC sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_e;

    localparam logic [31:0] PC_INCR              = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_sequencer_redirect_buffer.sv
// Holds a redirect that resolved while the core was stalled and selects live vs pending target.
module redirect_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_target
);

    logic        live_valid;
    logic [31:0] live_target;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    always_comb begin
        live_valid    = jump | branch_taken;
        live_target   = jump ? jump_target : branch_target;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (!stall) begin
            pend_valid_d = 1'b0;
        end else if (run && live_valid) begin
            // A later redirect in the same stall replaces the earlier one.
            pend_valid_d  = 1'b1;
            pend_target_d = live_target;
        end
        redirect_valid  = live_valid | pend_valid_q;
        redirect_target = live_valid ? live_target : pend_target_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'd0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the RV32I core: boot hold-off, fetch, redirects, stall, halt/resume.
// Build option PC_SEQ_MISALIGN_TRAP_EN sends misaligned redirect targets to TRAP_VECTOR.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
`endif
    parameter int unsigned BOOT_WAIT    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] pc_next,
    output logic        fetch_valid,
    output logic        halted,
    output logic [1:0]  seq_state,
    output logic [31:0] retired_count
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    ,
    output logic        misalign_trap
`endif
);

    localparam logic [31:0] BOOT_LAST = (BOOT_WAIT > 1) ? 32'(BOOT_WAIT - 1) : 32'd0;

    seq_state_e  state_q, state_d;
    logic [31:0] boot_cnt_q, boot_cnt_d;
    logic [31:0] retired_count_q, retired_count_d;
    logic        run;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] redirect_pc;
    logic        retire_ok;

    assign run = (state_q == ST_RUN);

    redirect_buffer u_redirect_buffer (
        .clk             (clk),
        .reset           (reset),
        .run             (run),
        .stall           (stall),
        .jump            (jump),
        .jump_target     (jump_target),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
    );

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    logic misaligned;
    logic trap_q, trap_d;

    assign misaligned  = redirect_valid && (redirect_target[1:0] != 2'b00);
    assign redirect_pc = misaligned ? TRAP_VECTOR : redirect_target;
    assign retire_ok   = !misaligned;
    assign trap_d      = run && !stall && misaligned;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) trap_q <= 1'b0;
        else       trap_q <= trap_d;
    end

    assign misalign_trap = trap_q;
`else
    assign redirect_pc = redirect_target & ~32'h3;
    assign retire_ok   = 1'b1;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no branch can infer a latch.
        state_d         = state_q;
        boot_cnt_d      = boot_cnt_q;
        retired_count_d = retired_count_q;
        pc_next         = RESET_VECTOR;
        fetch_valid     = 1'b0;
        case (state_q)
            ST_BOOT: begin
                boot_cnt_d = boot_cnt_q + 32'd1;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d    = ST_RUN;
                    boot_cnt_d = 32'd0;
                end
            end
            ST_RUN: begin
                if (stall) begin
                    pc_next = address;
                end else begin
                    fetch_valid = 1'b1;
                    pc_next     = redirect_valid ? redirect_pc : address + PC_INCR;
                    if (retire_ok) retired_count_d = retired_count_q + 32'd1;
                    // EBREAK still retires and follows any coincident redirect.
                    if (halt_req) state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                pc_next = address;
                if (resume) state_d = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values.
        if (reset) begin
            state_q         <= ST_BOOT;
            boot_cnt_q      <= 32'd0;
            retired_count_q <= 32'd0;
        end else begin
            state_q         <= state_d;
            boot_cnt_q      <= boot_cnt_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign halted        = (state_q == ST_HALT);
    assign seq_state     = state_q;
    assign retired_count = retired_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: behavioural model compared every cycle plus literal pins.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int          BW = 4;
    localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        stall, branch_taken, jump, halt_req, resume;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc_next;
    logic        fetch_valid, halted;
    logic [1:0]  seq_state;
    logic [31:0] retired_count;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    always #5 clk = ~clk;

    pc_sequencer dut (
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        .misalign_trap (misalign_trap),
`endif
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt_req      (halt_req),
        .resume        (resume),
        .pc_next       (pc_next),
        .fetch_valid   (fetch_valid),
        .halted        (halted),
        .seq_state     (seq_state),
        .retired_count (retired_count)
    );

    // Behavioural model state.
    int          m_mode;
    int          m_boot_cycles;
    bit          m_pend;
    logic [31:0] m_pend_tgt;
    logic [31:0] m_count;
    bit          m_trap_q;
    logic [31:0] e_pc;
    bit          e_fv, e_retire, e_trap, e_pend_next;
    int          e_mode_next;
    logic [31:0] e_pend_tgt_next;
    bit          preset_pending;

    // Literal expectations set by the stimulus for the current cycle.
    bit          armed;
    bit          lit_pc_en, lit_cnt_en, lit_st_en, lit_fv_en, lit_trap_en;
    logic [31:0] lit_pc, lit_cnt;
    int          lit_st;
    bit          lit_fv, lit_trap;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic model_eval();
        logic [31:0] tgt;
        bit          have;
        e_fv            = 1'b0;
        e_retire        = 1'b0;
        e_trap          = 1'b0;
        e_mode_next     = m_mode;
        e_pend_next     = stall ? m_pend : 1'b0;
        e_pend_tgt_next = m_pend_tgt;
        e_pc            = address;
        tgt             = 32'd0;
        have            = 1'b1;
        if (m_mode == M_BOOT) begin
            e_pc = RV;
            if (m_boot_cycles + 1 >= BW) e_mode_next = M_RUN;
        end else if (m_mode == M_HALT) begin
            if (resume) e_mode_next = M_RUN;
        end else if (stall) begin
            if (jump) begin
                e_pend_next = 1'b1; e_pend_tgt_next = jump_target;
            end else if (branch_taken) begin
                e_pend_next = 1'b1; e_pend_tgt_next = branch_target;
            end
        end else begin
            e_fv = 1'b1;
            if (jump)              tgt = jump_target;
            else if (branch_taken) tgt = branch_target;
            else if (m_pend)       tgt = m_pend_tgt;
            else                   have = 1'b0;
            if (!have)                            e_pc = address + 32'd4;
            else if (TRAP_ON && (tgt % 4) != 0) begin
                e_pc = TV; e_trap = 1'b1;
            end else                              e_pc = tgt - (tgt % 4);
            e_retire = !e_trap;
            if (halt_req) e_mode_next = M_HALT;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode <= M_BOOT; m_boot_cycles <= 0; m_pend <= 1'b0;
            m_pend_tgt <= 32'd0; m_count <= 32'd0; m_trap_q <= 1'b0;
        end else begin
            if (m_mode == M_BOOT) m_boot_cycles <= m_boot_cycles + 1;
            else                  m_boot_cycles <= 0;
            m_mode     <= e_mode_next;
            m_pend     <= e_pend_next;
            m_pend_tgt <= e_pend_tgt_next;
            m_count    <= (preset_pending ? 32'hFFFF_FFFE : m_count) + 32'(e_retire);
            m_trap_q   <= e_trap;
        end
    end

    always @(negedge clk) begin
        model_eval();
        if (armed) begin
            check("pc_next", pc_next, e_pc);
            check("fetch_valid", 32'(fetch_valid), 32'(e_fv));
            check("halted", 32'(halted), 32'(m_mode == M_HALT));
            check("seq_state", 32'(seq_state), 32'(m_mode));
            check("retired_count", retired_count, m_count);
`ifdef PC_SEQ_MISALIGN_TRAP_EN
            check("misalign_trap", 32'(misalign_trap), 32'(m_trap_q));
            if (lit_trap_en) check("lit_misalign_trap", 32'(misalign_trap), 32'(lit_trap));
`endif
            if (lit_pc_en)  check("lit_pc_next", pc_next, lit_pc);
            if (lit_cnt_en) check("lit_retired_count", retired_count, lit_cnt);
            if (lit_st_en)  check("lit_seq_state", 32'(seq_state), 32'(lit_st));
            if (lit_fv_en)  check("lit_fetch_valid", 32'(fetch_valid), 32'(lit_fv));
        end
    end

    task automatic step();
        @(posedge clk); #1;
        lit_pc_en = 0; lit_cnt_en = 0; lit_st_en = 0; lit_fv_en = 0; lit_trap_en = 0;
    endtask

    task automatic run_at(input logic [31:0] a);
        address = a; stall = 0; branch_taken = 0; jump = 0; halt_req = 0; resume = 0;
        branch_target = 32'd0; jump_target = 32'd0;
    endtask

    task automatic exp_pc(input logic [31:0] v);  lit_pc_en = 1;  lit_pc = v;  endtask
    task automatic exp_cnt(input logic [31:0] v); lit_cnt_en = 1; lit_cnt = v; endtask
    task automatic exp_st(input int v);           lit_st_en = 1;  lit_st = v;  endtask
    task automatic exp_fv(input bit v);           lit_fv_en = 1;  lit_fv = v;  endtask
    task automatic exp_trap(input bit v);         lit_trap_en = 1; lit_trap = v; endtask

    initial begin
        #100000;
        $display("FAIL watchdog: summary not reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; armed = 0; preset_pending = 0;
        run_at(32'd0);
        step();
        armed = 1;
        exp_pc(RV); exp_fv(0); exp_cnt(0); exp_st(M_BOOT);
        step();
        reset = 1'b0;
        // Boot hold-off; requests in the last two cycles must be ignored.
        for (int i = 0; i < BW; i++) begin
            run_at(32'd0);
            if (i >= 2) begin stall = 1; jump = 1; jump_target = 32'h500; halt_req = 1; end
            exp_pc(RV); exp_fv(0); exp_st(M_BOOT);
            step();
        end
        run_at(32'h0); exp_st(M_RUN); exp_pc(32'h4); exp_fv(1); step();
        run_at(32'h4); exp_pc(32'h8); step();
        run_at(32'h8); exp_pc(32'hC); step();
        run_at(32'h10); branch_taken = 1; branch_target = 32'h40; jump = 1; jump_target = 32'h80;
        exp_pc(32'h80); exp_cnt(3); step();
        // Stall with a jump arriving on the second stall cycle.
        run_at(32'h20); stall = 1; exp_pc(32'h20); exp_fv(0); exp_cnt(4); step();
        run_at(32'h20); stall = 1; jump = 1; jump_target = 32'h200; exp_pc(32'h20); step();
        run_at(32'h20); stall = 1; exp_pc(32'h20); exp_cnt(4); step();
        run_at(32'h20); exp_pc(32'h200); exp_cnt(4); exp_fv(1); step();
        // Overwrite during stall, then a live redirect beats the pending one.
        run_at(32'h200); stall = 1; branch_taken = 1; branch_target = 32'h240; step();
        run_at(32'h200); stall = 1; jump = 1; jump_target = 32'h280; step();
        run_at(32'h200); branch_taken = 1; branch_target = 32'h2C0; exp_pc(32'h2C0); step();
        run_at(32'h2C0); exp_pc(32'h2C4); step();
        // Halt requested under stall is ignored, then honoured.
        run_at(32'h30); stall = 1; halt_req = 1; exp_pc(32'h30); exp_st(M_RUN); step();
        run_at(32'h30); halt_req = 1; exp_pc(32'h34); exp_cnt(7); step();
        run_at(32'h34); stall = 1; jump = 1; jump_target = 32'h600; halt_req = 1;
        exp_pc(32'h34); exp_fv(0); exp_st(M_HALT); exp_cnt(8); step();
        run_at(32'h34); resume = 1; exp_pc(32'h34); exp_st(M_HALT); step();
        run_at(32'h34); exp_pc(32'h38); exp_st(M_RUN); exp_cnt(8); step();
        run_at(32'h38); halt_req = 1; branch_taken = 1; branch_target = 32'h70; exp_pc(32'h70); step();
        run_at(32'h70); resume = 1; exp_st(M_HALT); step();
        // Address wrap and misaligned targets.
        run_at(32'hFFFF_FFFC); exp_pc(32'h0); exp_cnt(10); step();
        run_at(32'h0); jump = 1; jump_target = 32'h102; exp_pc(32'h100); exp_cnt(11); step();
        run_at(32'h100); exp_pc(32'h104); exp_cnt(TRAP_ON ? 32'd11 : 32'd12);
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        exp_trap(1);
`endif
        step();
        run_at(32'h104); stall = 1; branch_taken = 1; branch_target = 32'h10B;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        exp_trap(0);
`endif
        step();
        run_at(32'h104); exp_pc(TRAP_ON ? 32'h100 : 32'h108); step();
        // Retire counter wrap via a preset of the count register.
        run_at(32'h200);
        @(negedge clk); #1;
        force dut.retired_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.retired_count_q;
        preset_pending = 1;
        step();
        preset_pending = 0;
        run_at(32'h204); exp_cnt(32'hFFFF_FFFF); step();
        run_at(32'h208); exp_cnt(32'h0); step();
        // Reset during a stall with a pending redirect.
        run_at(32'h40); stall = 1; jump = 1; jump_target = 32'h300; exp_pc(32'h40); step();
        run_at(32'h40); stall = 1; reset = 1'b1;
        exp_pc(RV); exp_fv(0); exp_st(M_BOOT); exp_cnt(0); step();
        reset = 1'b0;
        for (int i = 0; i < BW; i++) begin
            run_at(32'h40); exp_pc(RV); exp_st(M_BOOT); step();
        end
        run_at(32'h0); exp_pc(32'h4); exp_st(M_RUN); exp_cnt(0); step();
        run_at(32'h4); exp_pc(32'h8); exp_cnt(1); step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
